// File: rtl/mmss_bcd_counter.sv
// mmss_bcd_counter: BCD minutes:seconds time base for the stopwatch.
// Counts at run_tick in RUN, holds in PAUSED, steps the selected field at
// adj_tick in ADJUST. Optional lap freeze of the output digits is built when
// the LAP_FREEZE_EN macro is defined.
module mmss_bcd_counter #(
  parameter int unsigned MIN_MAX = 59,
  parameter int unsigned SEC_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_tick,
  input  logic       adj_tick,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       wrap,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PAUSED = 2'b01,
    ST_ADJUST = 2'b10
  } state_t;

  localparam logic [3:0] MIN_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MIN_O = 4'(MIN_MAX % 10);
  localparam logic [3:0] SEC_T = 4'(SEC_MAX / 10);
  localparam logic [3:0] SEC_O = 4'(SEC_MAX % 10);

  state_t     state_q, state_d;
  logic [3:0] so_q, st_q, mo_q, mt_q;
  logic [3:0] so_d, st_d, mo_d, mt_d;
  logic       wrap_q, wrap_d;

  logic       sec_at_max, min_at_max, illegal;
  logic [7:0] sec_inc, min_inc;

  // Next mode: adjust beats pause beats run, re-evaluated every cycle.
  always_comb begin
    state_d = ST_RUN;
    if (adj)        state_d = ST_ADJUST;
    else if (pause) state_d = ST_PAUSED;
  end

  // Field increments, terminal-value detection and out-of-range detection.
  always_comb begin
    sec_at_max = (st_q == SEC_T) && (so_q == SEC_O);
    min_at_max = (mt_q == MIN_T) && (mo_q == MIN_O);
    sec_inc    = (so_q == 4'd9) ? {st_q + 4'd1, 4'd0} : {st_q, so_q + 4'd1};
    min_inc    = (mo_q == 4'd9) ? {mt_q + 4'd1, 4'd0} : {mt_q, mo_q + 4'd1};
    illegal    = (so_q > 4'd9) || (mo_q > 4'd9) || (mt_q > 4'd9) ||
                 (st_q > SEC_T) || ((st_q == SEC_T) && (so_q > SEC_O)) ||
                 (mt_q > MIN_T) || ((mt_q == MIN_T) && (mo_q > MIN_O));
  end

  // Live count next-state: only the tick matching the current mode acts.
  always_comb begin
    so_d   = so_q;
    st_d   = st_q;
    mo_d   = mo_q;
    mt_d   = mt_q;
    wrap_d = 1'b0;
    if (illegal) begin
      so_d = '0;
      st_d = '0;
      mo_d = '0;
      mt_d = '0;
    end else if ((state_q == ST_RUN) && run_tick) begin
      if (sec_at_max) begin
        so_d = '0;
        st_d = '0;
        if (min_at_max) begin
          mo_d   = '0;
          mt_d   = '0;
          wrap_d = 1'b1;
        end else begin
          {mt_d, mo_d} = min_inc;
        end
      end else begin
        {st_d, so_d} = sec_inc;
      end
    end else if ((state_q == ST_ADJUST) && adj_tick) begin
      if (sel) begin
        if (sec_at_max) begin
          so_d = '0;
          st_d = '0;
        end else begin
          {st_d, so_d} = sec_inc;
        end
      end else begin
        if (min_at_max) begin
          mo_d = '0;
          mt_d = '0;
        end else begin
          {mt_d, mo_d} = min_inc;
        end
      end
    end
  end

  // State, live count and wrap registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      so_q    <= '0;
      st_q    <= '0;
      mo_q    <= '0;
      mt_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      so_q    <= so_d;
      st_q    <= st_d;
      mo_q    <= mo_d;
      mt_q    <= mt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign wrap = wrap_q;
  assign mode = state_q;

`ifdef LAP_FREEZE_EN
  logic        frz_q;
  logic [15:0] snap_q;

  // Lap freeze toggle; the snapshot takes the count as it stood before any
  // same-cycle increment. Heading into ADJUST drops the freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      frz_q  <= 1'b0;
      snap_q <= '0;
    end else if (state_d == ST_ADJUST) begin
      frz_q  <= 1'b0;
    end else if (lap && (state_q != ST_ADJUST)) begin
      if (frz_q) begin
        frz_q  <= 1'b0;
      end else begin
        frz_q  <= 1'b1;
        snap_q <= {mt_q, mo_q, st_q, so_q};
      end
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} =
    frz_q ? snap_q : {mt_q, mo_q, st_q, so_q};
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign {min_tens, min_ones, sec_tens, sec_ones} = {mt_q, mo_q, st_q, so_q};
`endif

endmodule
